// File: rtl/load_ctrl.sv
// load_ctrl: memory-stage load controller for the SRAM-like data port.
// Issues one aligned load at a time, waits for read data and extends the addressed lane.
module load_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [5:0]  opM,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        stall,
  output logic        rdata_valid,
  output logic [31:0] load_data,
  output logic        adel,
  output logic [31:0] badvaddr
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_CANCEL
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  op_q;
  logic        is_load;
  logic        misaligned;
  logic [1:0]  size_dec;
  logic        accept;
  logic        capture;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign data_wr = 1'b0;

  // Opcode decode: transfer size and alignment check for the incoming load
  always_comb begin
    is_load    = 1'b1;
    size_dec   = 2'd0;
    misaligned = 1'b0;
    case (opM)
      OP_LB, OP_LBU: size_dec = 2'd0;
      OP_LH, OP_LHU: begin
        size_dec   = 2'd1;
        misaligned = addr[0];
      end
      OP_LW: begin
        size_dec   = 2'd2;
        misaligned = |addr[1:0];
      end
      default: is_load = 1'b0;
    endcase
  end

  // Next-state and handshake/stall outputs
  always_comb begin
    state_nxt   = state;
    data_req    = 1'b0;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    adel        = 1'b0;
    badvaddr    = 32'h0;
    accept      = 1'b0;
    capture     = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_valid && is_load) begin
          if (misaligned) begin
            adel     = 1'b1;
            badvaddr = addr;
          end else if (!flush) begin
            accept    = 1'b1;
            stall     = 1'b1;
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        data_req = 1'b1;
        stall    = 1'b1;
        if (flush) begin
          // A request already fully answered has nothing left to drain
          state_nxt = (data_addr_ok && !data_data_ok) ? S_CANCEL : S_IDLE;
        end else if (data_addr_ok) begin
          if (data_data_ok) begin
            capture   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = data_data_ok ? S_IDLE : S_CANCEL;
        end else if (data_data_ok) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        rdata_valid = !flush;
        state_nxt   = S_IDLE;
      end
      S_CANCEL: begin
        stall = 1'b1;
        if (data_data_ok) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane extraction from the latched address and opcode
  always_comb begin
    byte_sel = 8'(data_rdata >> {data_addr[1:0], 3'b000});
    half_sel = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_q)
      OP_LB:   ext_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ext_data = {24'h0, byte_sel};
      OP_LH:   ext_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ext_data = {16'h0, half_sel};
      default: ext_data = data_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= 6'h0;
      data_addr <= 32'h0;
      data_size <= 2'd0;
      load_data <= 32'h0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q      <= opM;
        data_addr <= addr;
        data_size <= size_dec;
      end
      if (capture) load_data <= ext_data;
    end
  end

endmodule

// File: tb/tb_load_ctrl.sv
// tb_load_ctrl: directed load vectors with a scoreboard queue of expected load results.
// A negedge monitor pops one expectation for every rdata_valid strobe.
module tb_load_ctrl;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic [5:0]  opM;
  logic [31:0] addr;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        stall;
  logic        rdata_valid;
  logic [31:0] load_data;
  logic        adel;
  logic [31:0] badvaddr;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  load_ctrl dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .opM(opM), .addr(addr),
    .flush(flush), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .stall(stall), .rdata_valid(rdata_valid),
    .load_data(load_data), .adel(adel), .badvaddr(badvaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && rdata_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rdata_valid", 32'(rdata_valid), 32'd0);
      end else begin
        chk("load_data", load_data, exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    load_valid   = 1'b0;
    opM          = 6'h0;
    addr         = 32'h0;
    flush        = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
  endtask

  // Minimum-latency load: addr_ok and data_ok both in the first REQ cycle
  task automatic do_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd,
                         input logic [31:0] exp, input logic [1:0] size);
    int st_cnt;
    int rq_cnt;
    st_cnt = 0;
    rq_cnt = 0;
    exp_q.push_back(exp);
    next_cycle();
    load_valid = 1'b1; opM = op; addr = a;
    @(negedge clk);
    st_cnt += 32'(stall); rq_cnt += 32'(data_req);
    next_cycle();
    drive_idle();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rd;
    @(negedge clk);
    st_cnt += 32'(stall); rq_cnt += 32'(data_req);
    chk("data_size", 32'(data_size), 32'(size));
    chk("data_addr", data_addr, a);
    next_cycle();
    drive_idle();
    @(negedge clk);
    st_cnt += 32'(stall); rq_cnt += 32'(data_req);
    chk("done_rdata_valid", 32'(rdata_valid), 32'd1);
    next_cycle();
    @(negedge clk);
    st_cnt += 32'(stall); rq_cnt += 32'(data_req);
    chk("idle_rdata_valid", 32'(rdata_valid), 32'd0);
    chk("stall_cycles", 32'(st_cnt), 32'd2);
    chk("req_cycles", 32'(rq_cnt), 32'd1);
  endtask

  // Misaligned load: error flagged in the same cycle, nothing issued
  task automatic do_misaligned(input logic [5:0] op, input logic [31:0] a);
    next_cycle();
    load_valid = 1'b1; opM = op; addr = a;
    @(negedge clk);
    chk("adel", 32'(adel), 32'd1);
    chk("badvaddr", badvaddr, a);
    chk("adel_stall", 32'(stall), 32'd0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("adel_no_req", 32'(data_req), 32'd0);
    chk("adel_no_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_data_addr", data_addr, 32'h0);
    chk("rst_data_size", 32'(data_size), 32'd0);
    chk("rst_data_wr", 32'(data_wr), 32'd0);

    do_load(OP_LW,  32'h1000, 32'h89ABCDEF, 32'h89ABCDEF, 2'd2);
    do_load(OP_LB,  32'h1003, 32'h80FFFFFF, 32'hFFFFFF80, 2'd0);
    do_load(OP_LBU, 32'h1003, 32'h80FFFFFF, 32'h00000080, 2'd0);
    do_load(OP_LHU, 32'h1002, 32'h80017FFF, 32'h00008001, 2'd1);
    do_load(OP_LH,  32'h1002, 32'h80017FFF, 32'hFFFF8001, 2'd1);
    do_load(OP_LB,  32'h1000, 32'h1234567F, 32'h0000007F, 2'd0);
    do_load(OP_LBU, 32'h1001, 32'h0000AB00, 32'h000000AB, 2'd0);
    do_load(OP_LH,  32'h1000, 32'h1234F00D, 32'hFFFFF00D, 2'd1);

    do_misaligned(OP_LW, 32'h1002);
    do_misaligned(OP_LH, 32'h1001);

    // Non-load opcode is ignored
    next_cycle();
    load_valid = 1'b1; opM = OP_SW; addr = 32'h1001;
    @(negedge clk);
    chk("nonload_stall", 32'(stall), 32'd0);
    chk("nonload_adel", 32'(adel), 32'd0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("nonload_no_req", 32'(data_req), 32'd0);

    // Flush in WAIT: drain through CANCEL, no result delivered
    next_cycle();
    load_valid = 1'b1; opM = OP_LH; addr = 32'h1000;
    next_cycle();
    drive_idle();
    data_addr_ok = 1'b1;
    next_cycle();
    drive_idle();
    flush = 1'b1;
    @(negedge clk);
    chk("wait_flush_stall", 32'(stall), 32'd1);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive_idle();
      @(negedge clk);
      chk("cancel_stall", 32'(stall), 32'd1);
      chk("cancel_no_req", 32'(data_req), 32'd0);
    end
    next_cycle();
    drive_idle();
    data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("cancel_dataok_stall", 32'(stall), 32'd1);
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("after_cancel_stall", 32'(stall), 32'd0);
    chk("after_cancel_rvalid", 32'(rdata_valid), 32'd0);
    do_load(OP_LHU, 32'h1000, 32'h1234F00D, 32'h0000F00D, 2'd1);

    // Flush in REQ before the handshake returns to IDLE
    next_cycle();
    load_valid = 1'b1; opM = OP_LW; addr = 32'h3000;
    next_cycle();
    drive_idle();
    flush = 1'b1;
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("req_flush_stall", 32'(stall), 32'd0);
    chk("req_flush_no_req", 32'(data_req), 32'd0);

    // Flush in DONE suppresses the strobe
    next_cycle();
    load_valid = 1'b1; opM = OP_LW; addr = 32'h2000;
    next_cycle();
    drive_idle();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h55AA55AA;
    next_cycle();
    drive_idle();
    flush = 1'b1;
    @(negedge clk);
    chk("done_flush_rvalid", 32'(rdata_valid), 32'd0);

    // Reset during WAIT, then a late data_ok
    next_cycle();
    drive_idle();
    load_valid = 1'b1; opM = OP_LW; addr = 32'h4000;
    next_cycle();
    drive_idle();
    data_addr_ok = 1'b1;
    next_cycle();
    drive_idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("wrst_data_req", 32'(data_req), 32'd0);
    chk("wrst_stall", 32'(stall), 32'd0);
    chk("wrst_rvalid", 32'(rdata_valid), 32'd0);
    chk("wrst_load_data", load_data, 32'h0);
    chk("wrst_data_addr", data_addr, 32'h0);
    chk("wrst_data_size", 32'(data_size), 32'd0);
    chk("wrst_adel", 32'(adel), 32'd0);
    chk("wrst_badvaddr", badvaddr, 32'h0);
    next_cycle();
    data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("late_ok_stall", 32'(stall), 32'd0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    chk("late_ok_rvalid", 32'(rdata_valid), 32'd0);
    chk("late_ok_load_data", load_data, 32'h0);
    do_load(OP_LW, 32'h5004, 32'h01234567, 32'h01234567, 2'd2);

    repeat (2) next_cycle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
